uart_tx_arbiter: RTL and testbench

- Shares the single byte stream into the JTAG UART transmit path among NUM_SRC byte-stream producers.
- Grants whole messages round-robin. A grant is held until a terminator byte passes, a burst limit is reached, or the granted source stalls too long.
- Optionally prefixes each message with a source tag byte so the host can demultiplex.
- Sits between the producer blocks and the UART's input-stream side (canPeek/peek/consume_en convention).

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter merging NUM_SRC byte streams into one UART transmit stream.
// Grants whole messages, with an optional tag byte in front of each message.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter logic [7:0]  TERMINATOR  = 8'h0A,
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned STALL_LIMIT = 16,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  TAG_BASE    = 8'h30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_canPeek,
  input  logic [8*NUM_SRC-1:0]       src_peek,
  output logic [NUM_SRC-1:0]         src_consume_en,
  output logic                       out_canPeek,
  output logic [7:0]                 out_peek,
  input  logic                       out_consume_en,
  output logic                       busy,
  output logic [$clog2(NUM_SRC)-1:0] grant
);

  localparam int unsigned GW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] last_grant, grant_q, pick;
  logic          found;
  logic [7:0]    byte_cnt, stall_cnt;
  logic          sel_can;
  logic [7:0]    sel_byte;
  logic          take, body_done, stall_done;

  assign sel_can  = src_canPeek[grant_q];
  assign sel_byte = src_peek[{grant_q, 3'b000} +: 8];
  assign take     = (state == BODY) && out_consume_en && sel_can;

  // Terminator and burst limit on the same byte fold into one release.
  assign body_done  = take && ((sel_byte == TERMINATOR) || (byte_cnt == 8'(MAX_BURST - 1)));
  assign stall_done = (state == BODY) && !sel_can && (stall_cnt == 8'(STALL_LIMIT - 1));

  // Search starts just after the previous grant so the releasing source is last.
  always_comb begin
    logic [GW-1:0] idx;
    found = 1'b0;
    pick  = last_grant;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx = GW'((32'(last_grant) + i) % NUM_SRC);
      if (!found && src_canPeek[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (found) state_nx = HEADER_EN ? HDR : BODY;
      HDR:  if (out_consume_en) state_nx = BODY;
      BODY: if (body_done || stall_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= GW'(NUM_SRC - 1);
      grant_q    <= '0;
      byte_cnt   <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt  <= '0;
          stall_cnt <= '0;
          if (found) grant_q <= pick;
        end
        HDR: begin
          if (out_consume_en) begin
            byte_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        BODY: begin
          if (take) begin
            byte_cnt  <= byte_cnt + 8'd1;
            stall_cnt <= '0;
          end else if (!sel_can) begin
            stall_cnt <= stall_cnt + 8'd1;
          end
          if (body_done || stall_done) last_grant <= grant_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    src_consume_en = '0;
    out_canPeek    = 1'b0;
    out_peek       = '0;
    busy           = (state != IDLE);
    grant          = grant_q;
    case (state)
      HDR: begin
        out_canPeek = 1'b1;
        out_peek    = TAG_BASE + 8'(grant_q);
      end
      BODY: begin
        out_canPeek             = sel_can;
        out_peek                = sel_byte;
        src_consume_en[grant_q] = out_consume_en & sel_can;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue source models, an always-ready or
// windowed sink, and hand-computed output sequences with cycle positions.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic [3:0]  src_can;
  logic [31:0] src_pk;
  logic        out_ce;

  logic [3:0]  a_sce, b_sce;
  logic        a_cap, b_cap, a_busy, b_busy;
  logic [7:0]  a_pk, b_pk;
  logic [1:0]  a_grant, b_grant;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_SRC(4)) dut_a (
    .clock(clock), .reset(rst), .src_canPeek(src_can), .src_peek(src_pk),
    .src_consume_en(a_sce), .out_canPeek(a_cap), .out_peek(a_pk),
    .out_consume_en(out_ce), .busy(a_busy), .grant(a_grant)
  );

  uart_tx_arbiter #(.NUM_SRC(4), .MAX_BURST(4)) dut_b (
    .clock(clock), .reset(rst), .src_canPeek(src_can), .src_peek(src_pk),
    .src_consume_en(b_sce), .out_canPeek(b_cap), .out_peek(b_pk),
    .out_consume_en(out_ce), .busy(b_busy), .grant(b_grant)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] sbuf [4][16];
  int         shead [4];
  int         slen  [4];

  logic       lg_cap   [64];
  logic [7:0] lg_pk    [64];
  logic [3:0] lg_sce   [64];
  logic       lg_busy  [64];
  logic [1:0] lg_grant [64];
  logic [7:0] got  [$];
  int         gotc [$];

  task automatic load(input int s, input string str);
    for (int k = 0; k < str.len(); k++) sbuf[s][k] = str[k];
    shead[s] = 0;
    slen[s]  = str.len();
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    src_can = '0;
    src_pk  = '0;
    out_ce  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shead[i] = 0;
      slen[i]  = 0;
    end
    got.delete();
    gotc.delete();
    @(negedge clock);
    rst = 1'b1;
  endtask

  // Sink is ready outside the two hold windows; rst_at pulls reset low for that cycle.
  task automatic run(input int sel, input int ncyc, input int h1lo, input int h1hi,
                     input int h2lo, input int h2hi, input int rst_at);
    logic [3:0] sce;
    logic       cap;
    logic [7:0] pk;
    for (int c = 0; c < ncyc; c++) begin
      rst = (c == rst_at) ? 1'b0 : 1'b1;
      for (int i = 0; i < 4; i++) begin
        src_can[i]       = (shead[i] < slen[i]);
        src_pk[8*i +: 8] = src_can[i] ? sbuf[i][shead[i]] : 8'h00;
      end
      out_ce = !((c >= h1lo && c < h1hi) || (c >= h2lo && c < h2hi)) && (c != rst_at);
      #1;
      cap = (sel == 0) ? a_cap : b_cap;
      pk  = (sel == 0) ? a_pk  : b_pk;
      sce = (sel == 0) ? a_sce : b_sce;
      lg_cap[c]   = cap;
      lg_pk[c]    = pk;
      lg_sce[c]   = sce;
      lg_busy[c]  = (sel == 0) ? a_busy : b_busy;
      lg_grant[c] = (sel == 0) ? a_grant : b_grant;
      if (cap && out_ce) begin
        got.push_back(pk);
        gotc.push_back(c);
      end
      for (int i = 0; i < 4; i++) if (sce[i]) shead[i]++;
      @(negedge clock);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    src_can = 4'hF;
    src_pk  = 32'h41424344;
    out_ce  = 1'b1;
    @(negedge clock);
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_cap !== 1'b0) begin errors++; $display("FAIL reset_canpeek: got %b expected 0", a_cap); end
    checks++; if (a_sce !== 4'h0) begin errors++; $display("FAIL reset_consume: got %h expected 0", a_sce); end
    checks++; if (a_grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", a_grant); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", b_busy); end
  endtask

  task automatic test_single();
    logic [7:0] eb [4];
    int         ec [4];
    eb = '{8'h30, 8'h68, 8'h69, 8'h0A};
    ec = '{1, 2, 3, 4};
    do_reset();
    load(0, "hi\n");
    run(0, 8, -1, -1, -1, -1, -1);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL single_len: got %0d expected 4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== eb[k] || gotc[k] != ec[k]) begin
        errors++; $display("FAIL single_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], eb[k], ec[k]);
      end
    end
    checks++; if (lg_busy[0] !== 1'b0) begin errors++; $display("FAIL single_arb_busy: got %b expected 0", lg_busy[0]); end
    checks++; if (lg_busy[4] !== 1'b1) begin errors++; $display("FAIL single_busy_term: got %b expected 1", lg_busy[4]); end
    checks++; if (lg_busy[5] !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b expected 0", lg_busy[5]); end
    checks++; if (lg_grant[1] !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", lg_grant[1]); end
  endtask

  task automatic test_contention();
    logic [7:0] eb [6];
    int         ec [6];
    logic       leak;
    eb = '{8'h30, 8'h61, 8'h0A, 8'h32, 8'h61, 8'h0A};
    ec = '{1, 2, 3, 5, 6, 7};
    do_reset();
    load(0, "a\n");
    load(2, "a\n");
    run(0, 12, -1, -1, -1, -1, -1);
    checks++; if (got.size() != 6) begin errors++; $display("FAIL cont_len: got %0d expected 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== eb[k] || gotc[k] != ec[k]) begin
        errors++; $display("FAIL cont_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], eb[k], ec[k]);
      end
    end
    leak = 1'b0;
    for (int c = 0; c < 4; c++) leak = leak | lg_sce[c][2];
    checks++; if (leak !== 1'b0) begin errors++; $display("FAIL cont_src2_leak: got %b expected 0", leak); end
    checks++; if (lg_grant[5] !== 2'd2) begin errors++; $display("FAIL cont_grant2: got %0d expected 2", lg_grant[5]); end
  endtask

  task automatic test_burst();
    logic [7:0] eb [11];
    int         ec [11];
    logic [7:0] tb [8];
    int         tc [8];
    eb = '{8'h31, 8'h41, 8'h42, 8'h43, 8'h44, 8'h33, 8'h7A, 8'h0A, 8'h31, 8'h45, 8'h46};
    ec = '{1, 2, 3, 4, 5, 7, 8, 9, 11, 12, 13};
    do_reset();
    load(1, "ABCDEF");
    load(3, "z\n");
    run(1, 16, -1, -1, -1, -1, -1);
    checks++; if (got.size() != 11) begin errors++; $display("FAIL burst_len: got %0d expected 11", got.size()); end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== eb[k] || gotc[k] != ec[k]) begin
        errors++; $display("FAIL burst_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], eb[k], ec[k]);
      end
    end
    // Fourth body byte is also the terminator: exactly one release.
    tb = '{8'h30, 8'h61, 8'h62, 8'h63, 8'h0A, 8'h31, 8'h71, 8'h0A};
    tc = '{1, 2, 3, 4, 5, 7, 8, 9};
    do_reset();
    load(0, "abc\n");
    load(1, "q\n");
    run(1, 12, -1, -1, -1, -1, -1);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL burstterm_len: got %0d expected 8", got.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== tb[k] || gotc[k] != tc[k]) begin
        errors++; $display("FAIL burstterm_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], tb[k], tc[k]);
      end
    end
    checks++; if (lg_busy[6] !== 1'b0) begin errors++; $display("FAIL burstterm_idle: got %b expected 0", lg_busy[6]); end
  endtask

  task automatic test_stall();
    logic [7:0] eb [5];
    int         ec [5];
    int         idle_busy;
    logic [3:0] sce_or;
    eb = '{8'h30, 8'h61, 8'h31, 8'h62, 8'h0A};
    ec = '{1, 2, 20, 21, 22};
    do_reset();
    load(0, "a");
    load(1, "b\n");
    run(0, 26, -1, -1, -1, -1, -1);
    checks++; if (got.size() != 5) begin errors++; $display("FAIL stall_len: got %0d expected 5", got.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== eb[k] || gotc[k] != ec[k]) begin
        errors++; $display("FAIL stall_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], eb[k], ec[k]);
      end
    end
    idle_busy = 0;
    sce_or    = '0;
    for (int c = 3; c < 25; c++) if (lg_busy[c] === 1'b1 && lg_cap[c] === 1'b0) idle_busy++;
    for (int c = 3; c < 19; c++) sce_or = sce_or | lg_sce[c];
    checks++; if (idle_busy != 16) begin errors++; $display("FAIL stall_cycles: got %0d expected 16", idle_busy); end
    checks++; if (lg_busy[18] !== 1'b1) begin errors++; $display("FAIL stall_last_busy: got %b expected 1", lg_busy[18]); end
    checks++; if (lg_busy[19] !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", lg_busy[19]); end
    checks++; if (sce_or !== 4'h0) begin errors++; $display("FAIL stall_consume: got %h expected 0", sce_or); end
  endtask

  task automatic test_backpressure();
    logic [7:0] eb [4];
    int         ec [4];
    logic       all_busy;
    eb = '{8'h32, 8'h63, 8'h64, 8'h0A};
    ec = '{11, 12, 33, 34};
    do_reset();
    load(2, "cd\n");
    run(0, 40, 1, 11, 13, 33, -1);
    for (int c = 1; c < 11; c++) begin
      checks++;
      if (lg_pk[c] !== 8'h32 || lg_cap[c] !== 1'b1 || lg_sce[c] !== 4'h0) begin
        errors++; $display("FAIL bp_hold[%0d]: got peek=%h can=%b ce=%h expected peek=32 can=1 ce=0", c, lg_pk[c], lg_cap[c], lg_sce[c]);
      end
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_len: got %0d expected 4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== eb[k] || gotc[k] != ec[k]) begin
        errors++; $display("FAIL bp_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], eb[k], ec[k]);
      end
    end
    all_busy = 1'b1;
    for (int c = 1; c < 35; c++) all_busy = all_busy & lg_busy[c];
    checks++; if (all_busy !== 1'b1) begin errors++; $display("FAIL bp_no_stall: got %b expected 1", all_busy); end
    checks++; if (lg_busy[35] !== 1'b0) begin errors++; $display("FAIL bp_done: got %b expected 0", lg_busy[35]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] eb [10];
    int         ec [10];
    eb = '{8'h31, 8'h50, 8'h51, 8'h31, 8'h52, 8'h53, 8'h0A, 8'h33, 8'h7A, 8'h0A};
    ec = '{1, 2, 3, 6, 7, 8, 9, 11, 12, 13};
    do_reset();
    load(1, "PQRS\n");
    load(3, "z\n");
    run(0, 16, -1, -1, -1, -1, 4);
    checks++; if (lg_cap[5] !== 1'b0) begin errors++; $display("FAIL rmid_canpeek: got %b expected 0", lg_cap[5]); end
    checks++; if (lg_busy[5] !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", lg_busy[5]); end
    checks++; if (lg_sce[5] !== 4'h0) begin errors++; $display("FAIL rmid_consume: got %h expected 0", lg_sce[5]); end
    checks++; if (lg_grant[6] !== 2'd1) begin errors++; $display("FAIL rmid_grant: got %0d expected 1", lg_grant[6]); end
    checks++; if (got.size() != 10) begin errors++; $display("FAIL rmid_len: got %0d expected 10", got.size()); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== eb[k] || gotc[k] != ec[k]) begin
        errors++; $display("FAIL rmid_byte[%0d]: got %h@%0d expected %h@%0d", k, got[k], gotc[k], eb[k], ec[k]);
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    src_can = '0;
    src_pk  = '0;
    out_ce  = 1'b0;
    @(negedge clock);
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
